// File: rtl/bnn_classifier.sv
// Binary-NN output layer: scores each weights-ROM row as popcount(XNOR(image, row)),
// CHUNK_W bits per cycle, and returns the argmax class and its score over valid/ready.
module bnn_classifier #(
  parameter int IN_W        = 784,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK_W     = 56,
  parameter int ADDR_W      = 10,
  parameter int CLASS_W     = 4,
  parameter int SCORE_W     = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [IN_W-1:0]    pixels_i,
  input  logic               pixels_valid_i,
  output logic               pixels_ready_o,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic [IN_W-1:0]    weight_i,
  output logic [CLASS_W-1:0] class_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               class_valid_o,
  input  logic               class_ready_i,
  output logic               busy_o,
  output logic [2:0]         state_dbg_o
);

  localparam int NCHUNK = IN_W / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PC_W   = $clog2(CHUNK_W + 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and an offered result stays stable until taken.
  typedef enum logic [2:0] {IDLE, LOAD_W, ACCUM, CMP, DONE} state_t;

  state_t               state, state_next;
  logic [IN_W-1:0]      pix;
  logic [CLASS_W-1:0]   k, best;
  logic [CNT_W-1:0]     chunk;
  logic [SCORE_W-1:0]   acc, best_score;
  logic [CHUNK_W-1:0]   match;
  logic [PC_W-1:0]      pc;

  always_comb begin
    match = ~(pix[int'(chunk)*CHUNK_W +: CHUNK_W] ^ weight_i[int'(chunk)*CHUNK_W +: CHUNK_W]);
    pc = '0;
    for (int i = 0; i < CHUNK_W; i++) pc = pc + PC_W'(match[i]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pixels_valid_i) state_next = LOAD_W;
      LOAD_W:  state_next = ACCUM;
      ACCUM:   if (chunk == CNT_W'(NCHUNK - 1)) state_next = CMP;
      CMP:     state_next = (k == CLASS_W'(NUM_CLASSES - 1)) ? DONE : LOAD_W;
      DONE:    if (class_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      pix        <= '0;
      k          <= '0;
      chunk      <= '0;
      acc        <= '0;
      best       <= '0;
      best_score <= '0;
      rom_addr_o <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (pixels_valid_i) begin
          pix        <= pixels_i;
          k          <= '0;
          rom_addr_o <= '0;
        end
        LOAD_W: begin
          acc   <= '0;
          chunk <= '0;
        end
        ACCUM: begin
          acc   <= acc + SCORE_W'(pc);
          chunk <= chunk + 1'b1;
        end
        CMP: begin
          // Strict compare: on a tie the earlier (lower-index) class wins.
          if (k == '0 || acc > best_score) begin
            best       <= k;
            best_score <= acc;
          end
          if (k != CLASS_W'(NUM_CLASSES - 1)) begin
            k          <= k + 1'b1;
            rom_addr_o <= ADDR_W'(k) + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pixels_ready_o = (state == IDLE);
  assign class_valid_o  = (state == DONE);
  assign busy_o         = (state != IDLE);
  assign class_o        = class_valid_o ? best : '0;
  assign score_o        = class_valid_o ? best_score : '0;
  assign state_dbg_o    = state;

endmodule

// File: tb/tb_bnn_classifier.sv
// Directed bench for bnn_classifier with a registered-read weights ROM model.
module tb_bnn_classifier;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [783:0] pixels = '0;
  logic         pixels_valid = 1'b0;
  logic         pixels_ready;
  logic [9:0]   rom_addr;
  logic [783:0] weight = '0;
  logic [3:0]   class_idx;
  logic [9:0]   score;
  logic         class_valid;
  logic         class_ready = 1'b0;
  logic         busy;
  logic [2:0]   state_dbg;

  logic [783:0] mem [10];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) weight <= mem[rom_addr[3:0]];

  bnn_classifier dut (
    .clk_i(clk), .reset_i(reset), .pixels_i(pixels), .pixels_valid_i(pixels_valid),
    .pixels_ready_o(pixels_ready), .rom_addr_o(rom_addr), .weight_i(weight),
    .class_o(class_idx), .score_o(score), .class_valid_o(class_valid),
    .class_ready_i(class_ready), .busy_o(busy), .state_dbg_o(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [783:0] rand_vec();
    logic [783:0] v;
    for (int i = 0; i < 49; i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_state"}, state_dbg, 0);
    check({tag, "_ready"}, pixels_ready, 1);
    check({tag, "_valid"}, class_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addr"}, rom_addr, 0);
    check({tag, "_class"}, class_idx, 0);
    check({tag, "_score"}, score, 0);
  endtask

  task automatic accept(input logic [783:0] img);
    @(negedge clk);
    pixels = img;
    pixels_valid = 1'b1;
    @(posedge clk); #1;
    pixels_valid = 1'b0;
    pixels = rand_vec();
  endtask

  task automatic run_image(input logic [783:0] img, input int exp_cls, input int exp_score,
                           input int hold);
    int cyc;
    int addr_err;
    int stab_err;
    int exp_addr;
    accept(img);
    check("ready_low_busy", pixels_ready, 0);
    check("busy_high", busy, 1);
    cyc = 0;
    addr_err = 0;
    while (!class_valid && cyc < 400) begin
      exp_addr = (cyc / 16 > 9) ? 9 : cyc / 16;
      if (rom_addr != 10'(exp_addr)) addr_err++;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, 160);
    check("addr_seq", addr_err, 0);
    check("class", class_idx, exp_cls);
    check("score", score, exp_score);
    stab_err = 0;
    if (hold > 0) begin
      pixels_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!class_valid || class_idx != 4'(exp_cls) || score != 10'(exp_score) ||
            pixels_ready || !busy) stab_err++;
      end
      pixels_valid = 1'b0;
      check("hold_stable", stab_err, 0);
    end
    class_ready = 1'b1;
    @(posedge clk); #1;
    class_ready = 1'b0;
    check("ack_valid_low", class_valid, 0);
    check("ack_ready_high", pixels_ready, 1);
    check("ack_busy_low", busy, 0);
  endtask

  initial begin
    logic [783:0] p, m;

    for (int i = 0; i < 10; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;

    // Row 3 matches exactly, all others are the complement.
    p = rand_vec();
    for (int i = 0; i < 10; i++) mem[i] = ~p;
    mem[3] = p;
    run_image(p, 3, 784, 0);

    // Identical rows, each differing from the image in 300 bits: tie goes to class 0.
    p = rand_vec();
    m = '0;
    for (int i = 0; i < 300; i++) m[i] = 1'b1;
    for (int i = 0; i < 10; i++) mem[i] = p ^ m;
    run_image(p, 0, 484, 0);

    // Every row is the complement: all scores 0, class 0.
    p = rand_vec();
    for (int i = 0; i < 10; i++) mem[i] = ~p;
    run_image(p, 0, 0, 0);

    // Row 7 off by 5 bits, row 2 off by 6, the rest random; result held 20 cycles.
    p = rand_vec();
    for (int i = 0; i < 10; i++) mem[i] = rand_vec();
    m = '0;
    m[0] = 1'b1; m[100] = 1'b1; m[200] = 1'b1; m[300] = 1'b1; m[783] = 1'b1;
    mem[7] = p ^ m;
    m[500] = 1'b1;
    mem[2] = p ^ m;
    run_image(p, 7, 779, 20);

    // Reset during class 4 accumulation aborts cleanly.
    p = rand_vec();
    for (int i = 0; i < 10; i++) mem[i] = ~p;
    mem[5] = p;
    accept(p);
    repeat (70) @(posedge clk);
    #1;
    check("mid_state_accum", state_dbg, 2);
    check("mid_addr", rom_addr, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("abort");
    run_image(p, 5, 784, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
